// File: rtl/ex_mem_skid.sv
// EX->MEM two-entry skid buffer (head + skid) carrying ALU result, store data and condition flags.
// Define EX_MEM_BRANCH_RESOLVE_EN to add brz/brn inputs and the registered br_taken output.
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_z,
    input  logic              alu_n,
    input  logic [DATA_W-1:0] st_data,
    input  logic [RD_W-1:0]   rd,
    input  logic              reg_wrt,
    input  logic              mem_rd,
    input  logic              mem_wrt,
    input  logic              flag_upd,
    input  logic              flush,
`ifdef EX_MEM_BRANCH_RESOLVE_EN
    input  logic              brz,
    input  logic              brn,
    output logic              br_taken,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_st,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_reg_wrt,
    output logic              out_mem_rd,
    output logic              out_mem_wrt,
    output logic              flag_z,
    output logic              flag_n
);

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] st;
        logic [RD_W-1:0]   rd;
        logic              reg_wrt;
        logic              mem_rd;
        logic              mem_wrt;
    } entry_t;

    entry_t in_e;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   head_valid_q, head_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   flag_z_q, flag_z_d;
    logic   flag_n_q, flag_n_d;
    logic   in_xfer;
    logic   out_xfer;

    assign in_e     = {alu_out, st_data, rd, reg_wrt, mem_rd, mem_wrt};
    assign in_xfer  = in_valid & ~skid_valid_q;
    assign out_xfer = head_valid_q & out_ready;

    always_comb begin
        head_valid_d = head_valid_q;
        skid_valid_d = skid_valid_q;
        head_d       = head_q;
        skid_d       = skid_q;
        flag_z_d     = flag_z_q;
        flag_n_d     = flag_n_q;
        if (flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (head_valid_q && !out_xfer) begin
                if (in_xfer) begin
                    skid_d       = in_e;
                    skid_valid_d = 1'b1;
                end
            end else if (skid_valid_q) begin
                // skid valid implies in_ready=0, so nothing new arrives here
                head_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                head_valid_d = in_xfer;
                if (in_xfer) begin
                    head_d = in_e;
                end
            end
            if (in_xfer && flag_upd) begin
                flag_z_d = alu_z;
                flag_n_d = alu_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            head_q       <= '0;
            skid_q       <= '0;
            flag_z_q     <= 1'b0;
            flag_n_q     <= 1'b0;
        end else begin
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
            flag_z_q     <= flag_z_d;
            flag_n_q     <= flag_n_d;
        end
    end

`ifdef EX_MEM_BRANCH_RESOLVE_EN
    logic br_taken_q, br_taken_d;

    // resolved against flags as they stood before this transfer's update
    assign br_taken_d = in_xfer & ~flush &
                        ((brz & flag_z_q) | (brn & flag_n_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_taken_q <= 1'b0;
        end else begin
            br_taken_q <= br_taken_d;
        end
    end

    assign br_taken = br_taken_q;
`endif

    assign in_ready    = ~skid_valid_q;
    assign out_valid   = head_valid_q;
    assign out_alu     = head_q.alu;
    assign out_st      = head_q.st;
    assign out_rd      = head_q.rd;
    assign out_reg_wrt = head_q.reg_wrt;
    assign out_mem_rd  = head_q.mem_rd;
    assign out_mem_wrt = head_q.mem_wrt;
    assign flag_z      = flag_z_q;
    assign flag_n      = flag_n_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: vector table, directed corner sequences and a random
// phase, all checked against a queue scoreboard and a flag model.
module tb_ex_mem_skid;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] alu_out = '0;
    logic          alu_z = 1'b0;
    logic          alu_n = 1'b0;
    logic [DW-1:0] st_data = '0;
    logic [RW-1:0] rd = '0;
    logic          reg_wrt = 1'b0;
    logic          mem_rd = 1'b0;
    logic          mem_wrt = 1'b0;
    logic          flag_upd = 1'b0;
    logic          flush = 1'b0;
    logic          brz = 1'b0;
    logic          brn = 1'b0;
    logic          br_taken;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_alu;
    logic [DW-1:0] out_st;
    logic [RW-1:0] out_rd;
    logic          out_reg_wrt;
    logic          out_mem_rd;
    logic          out_mem_wrt;
    logic          flag_z;
    logic          flag_n;

    ex_mem_skid #(.DATA_W(DW), .RD_W(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n),
        .st_data(st_data), .rd(rd),
        .reg_wrt(reg_wrt), .mem_rd(mem_rd), .mem_wrt(mem_wrt),
        .flag_upd(flag_upd), .flush(flush),
`ifdef EX_MEM_BRANCH_RESOLVE_EN
        .brz(brz), .brn(brn), .br_taken(br_taken),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu(out_alu), .out_st(out_st), .out_rd(out_rd),
        .out_reg_wrt(out_reg_wrt), .out_mem_rd(out_mem_rd),
        .out_mem_wrt(out_mem_wrt),
        .flag_z(flag_z), .flag_n(flag_n)
    );

`ifndef EX_MEM_BRANCH_RESOLVE_EN
    assign br_taken = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] alu;
        logic [DW-1:0] st;
        logic [RW-1:0] rd;
        logic [2:0]    ctl;
    } sb_t;

    typedef struct {
        logic          iv;
        logic [DW-1:0] alu;
        logic [RW-1:0] rd;
        logic          ordy;
        logic          exp_ov;
        logic          exp_ir;
        logic [DW-1:0] exp_alu;
    } vec_t;

    sb_t  q[$];
    int   total = 0;
    int   bad = 0;
    logic mz = 1'b0;
    logic mn = 1'b0;
    logic mbr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] a,
                         input logic [RW-1:0] r, input logic fu,
                         input logic z, input logic n,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        alu_out   = a;
        st_data   = ~a;
        rd        = r;
        reg_wrt   = a[0];
        mem_rd    = a[1];
        mem_wrt   = a[2];
        flag_upd  = fu;
        alu_z     = z;
        alu_n     = n;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic model_reset();
        q.delete();
        mz  = 1'b0;
        mn  = 1'b0;
        mbr = 1'b0;
    endtask

    // Evaluate the handshake mid-cycle, advance one edge, then check state.
    task automatic tick();
        logic ix, ox;
        sb_t  e;
        #3;
        ix = in_valid && in_ready;
        ox = out_valid && out_ready;
        if (ox) begin
            if (q.size() == 0) begin
                chk("sb_unexpected_out", 64'(out_alu), 64'hdead);
            end else begin
                e = q.pop_front();
                chk("sb_alu", 64'(out_alu), 64'(e.alu));
                chk("sb_st", 64'(out_st), 64'(e.st));
                chk("sb_rd", 64'(out_rd), 64'(e.rd));
                chk("sb_ctl", 64'({out_mem_wrt, out_mem_rd, out_reg_wrt}),
                    64'(e.ctl));
            end
        end
        mbr = 1'b0;
        if (flush) begin
            q.delete();
        end else if (ix) begin
            e.alu = alu_out;
            e.st  = st_data;
            e.rd  = rd;
            e.ctl = {mem_wrt, mem_rd, reg_wrt};
            q.push_back(e);
            mbr = (brz && mz) || (brn && mn);
            if (flag_upd) begin
                mz = alu_z;
                mn = alu_n;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("flag_z", 64'(flag_z), 64'(mz));
        chk("flag_n", 64'(flag_n), 64'(mn));
`ifdef EX_MEM_BRANCH_RESOLVE_EN
        chk("br_taken", 64'(br_taken), 64'(mbr));
`endif
    endtask

    vec_t vt[10];

    initial begin
        vt[0] = '{1'b1, 32'h5,  5'd3, 1'b1, 1'b1, 1'b1, 32'h5};
        vt[1] = '{1'b0, 32'h0,  5'd0, 1'b1, 1'b0, 1'b1, 32'h0};
        vt[2] = '{1'b1, 32'h11, 5'd1, 1'b0, 1'b1, 1'b1, 32'h11};
        vt[3] = '{1'b1, 32'h22, 5'd2, 1'b0, 1'b1, 1'b0, 32'h11};
        vt[4] = '{1'b1, 32'h33, 5'd4, 1'b0, 1'b1, 1'b0, 32'h11};
        vt[5] = '{1'b0, 32'h0,  5'd0, 1'b1, 1'b1, 1'b1, 32'h22};
        vt[6] = '{1'b1, 32'h44, 5'd5, 1'b1, 1'b1, 1'b1, 32'h44};
        vt[7] = '{1'b1, 32'h55, 5'd6, 1'b0, 1'b1, 1'b0, 32'h44};
        vt[8] = '{1'b0, 32'h0,  5'd0, 1'b1, 1'b1, 1'b1, 32'h55};
        vt[9] = '{1'b0, 32'h0,  5'd0, 1'b1, 1'b0, 1'b1, 32'h0};

        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_flags", 64'({flag_z, flag_n}), 64'd0);
        chk("rst_out_alu", 64'(out_alu), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);
        chk("rst_br", 64'(br_taken), 64'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vt[i].iv, vt[i].alu, vt[i].rd, 1'b0, 1'b0, 1'b0,
                  vt[i].ordy, 1'b0);
            tick();
            chk($sformatf("vec%0d_ov", i), 64'(out_valid), 64'(vt[i].exp_ov));
            chk($sformatf("vec%0d_ir", i), 64'(in_ready), 64'(vt[i].exp_ir));
            if (vt[i].exp_ov)
                chk($sformatf("vec%0d_alu", i), 64'(out_alu),
                    64'(vt[i].exp_alu));
        end

        drive(1'b1, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("flag_z_set", 64'(flag_z), 64'd1);
        drive(1'b1, 32'h8, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("flag_n_hold", 64'(flag_n), 64'd0);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

`ifdef EX_MEM_BRANCH_RESOLVE_EN
        drive(1'b1, 32'h9, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        brz = 1'b1;
        tick();
        chk("br_z_taken", 64'(br_taken), 64'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        brz = 1'b0;
        tick();
        chk("br_one_cycle", 64'(br_taken), 64'd0);
        drive(1'b1, 32'ha, 5'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        brn = 1'b1;
        tick();
        chk("br_n_not_taken", 64'(br_taken), 64'd0);
        brn = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
`endif

        drive(1'b1, 32'h66, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h67, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h68, 5'd13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("flush_ov", 64'(out_valid), 64'd0);
        chk("flush_flag_n", 64'(flag_n), 64'd0);
        chk("flush_ir", 64'(in_ready), 64'd1);

        drive(1'b1, 32'h69, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("flush_in_flag_n", 64'(flag_n), 64'd0);
        chk("flush_in_ov", 64'(out_valid), 64'd0);

        drive(1'b1, 32'h88, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov", 64'(out_valid), 64'd0);
        chk("arst_flags", 64'({flag_z, flag_n}), 64'd0);
        chk("arst_ir", 64'(in_ready), 64'd1);
        chk("arst_alu", 64'(out_alu), 64'd0);
        model_reset();
        drive(1'b1, 32'h77, 5'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_alu", 64'(out_alu), 64'h77);
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 6, $urandom, 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
            brz = 1'($urandom);
            brn = 1'($urandom);
            tick();
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        brz = 1'b0;
        brn = 1'b0;
        tick();
        tick();
        tick();
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid.md
EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of the ALU result and store-data paths.
REQ-002 Parameter RD_W, default 5, width of the destination register index.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  in  1  upstream execute stage holds a completed ALU result.
REQ-006 in_ready  out  1  the block accepts the upstream result this cycle.
REQ-007 alu_out  in  DATA_W  ALU sum (a-path plus b-path).
REQ-008 alu_z / alu_n  in  1 each  ALU zero and negative flags for alu_out.
REQ-009 st_data  in  DATA_W  store data forwarded to memory.
REQ-010 rd  in  RD_W  destination register index.
REQ-011 reg_wrt / mem_rd / mem_wrt / flag_upd  in  1 each  control bits travelling with the result.
REQ-012 flush  in  1  synchronous kill of all held entries.
REQ-013 out_valid  out  1  head entry is presented downstream.
REQ-014 out_ready  in  1  memory stage consumes the head entry.
REQ-015 out_alu, out_st, out_rd, out_reg_wrt, out_mem_rd, out_mem_wrt  out  as inputs  fields of the head entry.
REQ-016 flag_z / flag_n  out  1 each  architectural condition-flag register.

Function
REQ-017 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-018 Storage is two entries: a head register and a skid register, in FIFO order.
REQ-019 in_ready SHALL equal NOT skid_valid, driven from a register with no combinational path from out_ready.
REQ-020 Latency: with the block empty, an accepted entry SHALL appear on out_valid and the out_* fields in the next cycle.
REQ-021 If head is empty, or head is consumed in the same cycle, an accepted entry SHALL load head, or skid when skid is occupied; skid SHALL move to head whenever head is consumed.
REQ-022 Accept while head is full and not consumed SHALL load skid; in_ready then deasserts the next cycle.
REQ-023 Simultaneous in and out transfers with both entries occupied are impossible (in_ready = 0); with one entry, occupancy SHALL stay at 1.
REQ-024 out_* fields SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-025 flag_z/flag_n SHALL load alu_z/alu_n on the clock edge of an in transfer with flag_upd = 1; otherwise they hold.
REQ-026 flush SHALL clear head_valid and skid_valid on the next edge, discard any same-cycle in transfer including its flag update, and leave flag_z/flag_n unchanged.
REQ-027 A flush that coincides with an out transfer SHALL still count as the downstream consuming the head entry.
REQ-028 Data fields of an invalid entry are don't-care, except that they SHALL be zero after reset.

Reset
REQ-029 rst_n low SHALL immediately force out_valid = 0, skid_valid = 0, in_ready = 1, flag_z = 0, flag_n = 0, all out_* = 0, and br_taken = 0 when present.
REQ-030 Reset asserted mid-transfer SHALL discard both entries; the first rising edge after release SHALL be able to accept an entry.

Configuration
REQ-031 Macro EX_MEM_BRANCH_RESOLVE_EN, when defined, SHALL add inputs brz and brn (1 bit each) and a registered output br_taken (1 bit).
REQ-032 With the macro defined, br_taken SHALL be 1 for exactly one cycle after an in transfer where (brz && flag_z) || (brn && flag_n), evaluated on the flag values held before that transfer's own flag update; it is suppressed by flush.
REQ-033 With the macro undefined, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset then single transfer: alu_out=0x0000_0005, rd=3, in_valid for 1 cycle, out_ready=1 -> out_valid=1 next cycle with out_alu=0x5 and out_rd=3, then out_valid=0.
REQ-035 Backpressure: out_ready=0, send 0x11 then 0x22 -> in_ready=0 after the second; raise out_ready -> 0x11 then 0x22 delivered in order, with no loss and no duplicate.
REQ-036 Flags: accept alu_out=0, alu_z=1, flag_upd=1 -> flag_z=1; then accept alu_n=1 with flag_upd=0 -> flag_n stays 0.
REQ-037 Flush with both entries full and in_valid=1 carrying flag_upd=1, alu_n=1 -> out_valid=0 next cycle, flag_n unchanged, in_ready=1.
REQ-038 Async reset pulse mid-stream (rst_n low between edges) -> out_valid=0 and flags=0 immediately, before the next edge.
REQ-039 With the macro defined and flag_z=1, accept brz=1 -> br_taken=1 for 1 cycle; accept brn=1 with flag_n=0 -> br_taken stays 0.
